// File: rtl/dmem_stage.sv
// dmem_stage: data-memory access stage. It runs a req/ack transaction against a
// variable-latency memory, stalls the pipeline while the access is in flight, and
// registers the aligned, extended load data for MEM/WB.
module dmem_stage #(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              memread,
  input  logic              memwrite,
  input  logic [1:0]        length,
  input  logic              sign,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              stall,
  output logic              misalign,
  output logic              bus_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  state_t            r_state, w_state_nxt;
  logic [7:0]        r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_len;
  logic              r_sign, r_we, r_abort;
  logic [3:0]        r_be;
  logic [31:0]       r_wdata, r_rdata;

  logic              w_aligned, w_valid;
  logic [3:0]        w_be;
  logic [31:0]       w_wd;
  logic [1:0]        w_off, w_len;
  logic              w_sign, w_read, w_take, w_timeout;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_ext;
  logic              w_unused;

  assign rdata    = r_rdata;
  assign w_unused = ^addr[31:ADDR_W];

  // Decode the live EX/MEM request: legality, byte enables, lane-replicated store data.
  always_comb begin
    w_aligned = 1'b1;
    w_be      = 4'b1111;
    w_wd      = wdata;
    case (length)
      2'b00: begin
        w_be = 4'b0001 << addr[1:0];
        w_wd = {4{wdata[7:0]}};
      end
      2'b01: begin
        w_aligned = ~addr[0];
        w_be      = 4'b0011 << addr[1:0];
        w_wd      = {2{wdata[15:0]}};
      end
      2'b10:   w_aligned = (addr[1:0] == 2'b00);
      default: w_aligned = 1'b0;
    endcase
    w_valid = (memread | memwrite) & w_aligned;
  end

  // Next-state and output decode; IDLE drives the bus from live inputs, REQ from captured registers.
  always_comb begin
    w_state_nxt = r_state;
    stall       = 1'b0;
    misalign    = 1'b0;
    bus_err     = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_be      = '0;
    mem_wdata   = '0;
    w_take      = 1'b0;
    w_timeout   = 1'b0;
    w_off       = addr[1:0];
    w_len       = length;
    w_sign      = sign;
    w_read      = memread;
    case (r_state)
      S_IDLE: begin
        if (w_valid) begin
          stall       = 1'b1;
          mem_req     = 1'b1;
          mem_we      = memwrite;
          mem_addr    = addr[ADDR_W-1:2];
          mem_be      = w_be;
          mem_wdata   = w_wd;
          w_take      = mem_ack;
          w_state_nxt = mem_ack ? S_DONE : S_REQ;
        end else if (memread | memwrite) begin
          misalign = 1'b1;
        end
      end
      S_REQ: begin
        stall     = 1'b1;
        mem_req   = 1'b1;
        mem_we    = r_we;
        mem_addr  = r_addr[ADDR_W-1:2];
        mem_be    = r_be;
        mem_wdata = r_wdata;
        w_off     = r_addr[1:0];
        w_len     = r_len;
        w_sign    = r_sign;
        w_read    = ~r_we;
        if (mem_ack) begin
          w_take      = 1'b1;
          w_state_nxt = S_DONE;
        end else if (r_cnt == 8'(TIMEOUT - 1)) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        bus_err     = r_abort;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // Reset holds every handshake output quiet even though state only clears at the edge.
    if (!rstn) begin
      stall     = 1'b0;
      misalign  = 1'b0;
      bus_err   = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_be    = '0;
      mem_wdata = '0;
    end
  end

  // Lane select and sign/zero extension of the raw memory word.
  always_comb begin
    case (w_off)
      2'd0:    w_byte = mem_rdata[7:0];
      2'd1:    w_byte = mem_rdata[15:8];
      2'd2:    w_byte = mem_rdata[23:16];
      default: w_byte = mem_rdata[31:24];
    endcase
    w_half = w_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (w_len)
      2'b00:   w_ext = {{24{w_sign & w_byte[7]}}, w_byte};
      2'b01:   w_ext = {{16{w_sign & w_half[15]}}, w_half};
      default: w_ext = mem_rdata;
    endcase
  end

  // State, wait counter, request capture and load-data register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_sign  <= 1'b0;
      r_we    <= 1'b0;
      r_be    <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_abort <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && w_valid) begin
        r_addr  <= addr[ADDR_W-1:0];
        r_len   <= length;
        r_sign  <= sign;
        r_we    <= memwrite;
        r_be    <= w_be;
        r_wdata <= w_wd;
        r_cnt   <= '0;
        r_abort <= 1'b0;
      end
      if (r_state == S_REQ && !mem_ack) r_cnt <= r_cnt + 8'd1;
      if (r_state == S_DONE) r_abort <= 1'b0;
      if (w_take && w_read) r_rdata <= w_ext;
      if (w_timeout) begin
        r_abort <= 1'b1;
        if (!r_we) r_rdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_stage.sv
// Testbench for dmem_stage: scenario tasks with a scoreboard of expected
// per-access results (stall length, load data, bus error).
module tb_dmem_stage;
  localparam int ADDR_W  = 12;
  localparam int TIMEOUT = 15;

  logic              clk, rstn, memread, memwrite, sign, mem_ack;
  logic [1:0]        length;
  logic [31:0]       addr, wdata, mem_rdata, rdata, mem_wdata;
  logic              stall, misalign, bus_err, mem_req, mem_we;
  logic [ADDR_W-3:0] mem_addr;
  logic [3:0]        mem_be;

  dmem_stage #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rstn(rstn), .memread(memread), .memwrite(memwrite),
    .length(length), .sign(sign), .addr(addr), .wdata(wdata),
    .rdata(rdata), .stall(stall), .misalign(misalign), .bus_err(bus_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          stalls;
    logic [31:0] rdata;
    logic        berr;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] cur_rdata = '0;

  function automatic logic [3:0] m_be(input logic [1:0] len, input logic [31:0] a);
    logic [3:0] be;
    int unsigned o;
    o  = a[1:0];
    be = '0;
    if (len == 2'b10) be = 4'b1111;
    else begin
      be[o] = 1'b1;
      if (len == 2'b01) be[o + 1] = 1'b1;
    end
    return be;
  endfunction

  function automatic logic [31:0] m_wd(input logic [1:0] len, input logic [31:0] wd);
    if (len == 2'b00) return wd[7:0] * 32'h01010101;
    if (len == 2'b01) return wd[15:0] * 32'h00010001;
    return wd;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] len, input logic sg,
                                         input logic [31:0] a, input logic [31:0] rm);
    logic [31:0] sh;
    sh = rm >> (8 * a[1:0]);
    if (len == 2'b00) return sg ? 32'($signed(sh[7:0])) : {24'h0, sh[7:0]};
    if (len == 2'b01) return sg ? 32'($signed(sh[15:0])) : {16'h0, sh[15:0]};
    return rm;
  endfunction

  // k < 0 means the memory never acknowledges.
  task automatic run_access(input string nm, input logic rd, input logic [1:0] len,
                            input logic sg, input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] rm, input int k);
    exp_t              e;
    logic [ADDR_W-3:0] ea;
    logic [3:0]        ebe;
    logic [31:0]       ewd;
    int                nst;
    bit                done;
    logic              acked;
    acked    = (k >= 0) && (k <= TIMEOUT);
    e.stalls = acked ? k + 1 : TIMEOUT + 1;
    e.berr   = ~acked;
    e.rdata  = rd ? (acked ? m_load(len, sg, a, rm) : 32'h0) : cur_rdata;
    sb.push_back(e);
    cur_rdata = e.rdata;
    ea  = a[ADDR_W-1:2];
    ebe = m_be(len, a);
    ewd = m_wd(len, wd);
    memread = rd; memwrite = ~rd; length = len; sign = sg; addr = a; wdata = wd;
    mem_rdata = rm;
    nst = 0; done = 0;
    for (int c = 0; c < 64; c++) begin
      mem_ack = (c == k);
      @(negedge clk);
      if (!stall) begin done = 1; break; end
      nst++;
      checks++;
      if (mem_req !== 1'b1 || mem_we !== ~rd || mem_addr !== ea || mem_be !== ebe ||
          mem_wdata !== ewd || misalign !== 1'b0) begin
        errors++;
        $display("FAIL %s bus c%0d: req=%b we=%b addr=%h be=%b wd=%h mis=%b, want 1 %b %h %b %h 0",
                 nm, c, mem_req, mem_we, mem_addr, mem_be, mem_wdata, misalign, ~rd, ea, ebe, ewd);
      end
      @(posedge clk); #1;
    end
    mem_ack = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s done: stall never dropped within 64 cycles", nm);
    end
    e = sb.pop_front();
    checks++;
    if (nst !== e.stalls) begin
      errors++;
      $display("FAIL %s stall_len: got %0d want %0d", nm, nst, e.stalls);
    end
    checks++;
    if (rdata !== e.rdata) begin
      errors++;
      $display("FAIL %s rdata: got %h want %h", nm, rdata, e.rdata);
    end
    checks++;
    if (bus_err !== e.berr || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL %s done_flags: bus_err=%b mem_req=%b want %b 0", nm, bus_err, mem_req, e.berr);
    end
    @(posedge clk); #1;
    memread = 1'b0; memwrite = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    memread = 0; memwrite = 0; length = 0; sign = 0; addr = 0; wdata = 0;
    mem_ack = 0; mem_rdata = 0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if ({stall, mem_req, mem_we, misalign, bus_err} !== 5'b0 || mem_be !== 4'h0 ||
          mem_addr !== '0 || mem_wdata !== 32'h0 || rdata !== 32'h0) begin
        errors++;
        $display("FAIL reset_%0d: st=%b req=%b we=%b mis=%b be_err=%b be=%b ad=%h wd=%h rd=%h, want all 0",
                 i, stall, mem_req, mem_we, misalign, bus_err, mem_be, mem_addr, mem_wdata, rdata);
      end
      @(posedge clk); #1;
      rstn = 1'b1;
    end
  endtask

  task automatic test_lb();
    run_access("lb_sign", 1, 2'b00, 1, 32'h003, 0, 32'h80FF1234, 0);
    checks++;
    if (cur_rdata !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_sign model: got %h want ffffff80", cur_rdata); end
    run_access("lb_zero", 1, 2'b00, 0, 32'h003, 0, 32'h80FF1234, 0);
  endtask

  task automatic test_sh();
    run_access("sh", 0, 2'b01, 0, 32'h006, 32'h0000ABCD, 32'h5555AAAA, 1);
  endtask

  task automatic test_back_to_back();
    run_access("lw_k3", 1, 2'b10, 0, 32'h010, 0, 32'hDEADBEEF, 3);
    run_access("lw_b2b", 1, 2'b10, 0, 32'h014, 0, 32'h12345678, 0);
  endtask

  task automatic test_misalign();
    logic [1:0] lens [2];
    logic [31:0] adrs [2];
    lens[0] = 2'b01; adrs[0] = 32'h005;
    lens[1] = 2'b11; adrs[1] = 32'h010;
    for (int i = 0; i < 2; i++) begin
      memread = 1; length = lens[i]; addr = adrs[i]; mem_ack = 0;
      @(negedge clk);
      checks++;
      if (misalign !== 1'b1 || mem_req !== 1'b0 || stall !== 1'b0) begin
        errors++;
        $display("FAIL misalign_%0d: mis=%b req=%b stall=%b want 1 0 0", i, misalign, mem_req, stall);
      end
      @(posedge clk); #1;
      memread = 0;
      @(negedge clk);
      checks++;
      if (misalign !== 1'b0 || rdata !== cur_rdata) begin
        errors++;
        $display("FAIL misalign_after_%0d: mis=%b rdata=%h want 0 %h", i, misalign, rdata, cur_rdata);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout();
    run_access("lw_timeout", 1, 2'b10, 0, 32'h020, 0, 32'hCAFEF00D, -1);
    mem_ack = 1'b1;
    @(negedge clk);
    checks++;
    if (stall !== 1'b0 || mem_req !== 1'b0 || bus_err !== 1'b0 || rdata !== 32'h0) begin
      errors++;
      $display("FAIL late_ack: stall=%b req=%b bus_err=%b rdata=%h want 0 0 0 0", stall, mem_req, bus_err, rdata);
    end
    @(posedge clk); #1;
    mem_ack = 1'b0;
  endtask

  task automatic test_reset_mid();
    run_access("lw_pre", 1, 2'b10, 0, 32'h030, 0, 32'h0BADF00D, 0);
    memread = 1; length = 2'b10; addr = 32'h040; mem_ack = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rstn = 1'b0;
    @(negedge clk);
    checks++;
    if (stall !== 1'b0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_low: stall=%b req=%b want 0 0", stall, mem_req);
    end
    @(posedge clk); #1;
    rstn = 1'b1; memread = 0;
    cur_rdata = '0;
    @(negedge clk);
    checks++;
    if (stall !== 1'b0 || mem_req !== 1'b0 || rdata !== 32'h0 || bus_err !== 1'b0 || misalign !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_after: stall=%b req=%b rdata=%h berr=%b mis=%b want 0 0 0 0 0",
               stall, mem_req, rdata, bus_err, misalign);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random_loads();
    logic [1:0]  len;
    logic [31:0] a;
    for (int i = 0; i < 10; i++) begin
      len = 2'($urandom_range(0, 2));
      a   = $urandom & 32'hFFF;
      if (len == 2'b01) a[0] = 1'b0;
      if (len == 2'b10) a[1:0] = 2'b00;
      run_access("rand_ld", 1, len, 1'($urandom_range(0, 1)), a, 0, $urandom,
                 int'($urandom_range(0, 4)));
    end
  endtask

  initial begin
    test_reset();
    test_lb();
    test_sh();
    test_back_to_back();
    test_misalign();
    test_timeout();
    test_reset_mid();
    test_random_loads();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_stage.md
# dmem_stage

Data-memory access stage between the EX/MEM and MEM/WB pipeline registers. It consumes the latched ALU result (address), store data, length, sign and read/write controls. It runs a req/ack transaction with a variable-latency data memory, stalling the pipeline until the access completes. It produces the aligned, extended load data that MEM/WB captures.

## Interface
- ADDR_W, 12, byte-address bits used; upper address bits are ignored.
- TIMEOUT, 15, maximum REQ cycles without ack before the access is aborted; range 1..255.

- clk  in  1  clock, rising edge
- rstn  in  1  reset, synchronous, active-low
- memread  in  1  load request from EX/MEM
- memwrite  in  1  store request from EX/MEM; never high together with memread
- length  in  2  00 byte, 01 half, 10 word, 11 illegal
- sign  in  1  1 = sign-extend loads, 0 = zero-extend
- addr  in  32  byte address (ALU result)
- wdata  in  32  store data, right-justified
- rdata  out  32  load data to MEM/WB, registered
- stall  out  1  1 = PC, IF/ID, ID/EX, EX/MEM hold and MEM/WB must not advance
- misalign  out  1  one-cycle flag: access rejected (misaligned or length=11)
- bus_err  out  1  one-cycle flag: access aborted by timeout
- mem_req  out  1  memory request
- mem_we  out  1  1 = write
- mem_addr  out  ADDR_W-2  word address = addr[ADDR_W-1:2]
- mem_be  out  4  byte enables, bit n = bits 8n+7:8n
- mem_wdata  out  32  lane-replicated store data
- mem_ack  in  1  memory completion; mem_rdata valid when high on a read
- mem_rdata  in  32  raw word read data

## Operation
- FSM states IDLE, REQ, DONE. Reset → IDLE.
- An access is valid when (memread|memwrite) is high, length≠11, and it is aligned. Half accesses need addr[0]=0; word accesses need addr[1:0]=0.
- IDLE, valid access:
  - mem_req=1 combinationally, driven from the live inputs.
  - stall=1.
  - addr, length, sign, we, be, and wdata are captured into registers.
  - If mem_ack=1 → DONE, otherwise → REQ.
- IDLE, invalid access: misalign=1 this cycle. No mem_req, stall=0, rdata unchanged, stay IDLE.
- REQ:
  - mem_req=1, with all mem_* outputs driven from the captured registers and held stable.
  - stall=1.
  - The wait counter increments each cycle.
  - On mem_ack=1 → DONE.
  - When the counter reaches TIMEOUT without ack → DONE with abort. The request drops and no further ack is expected.
- DONE:
  - stall=0, mem_req=0.
  - rdata holds the final value for MEM/WB to sample at this edge.
  - bus_err=1 if the access was aborted.
  - → IDLE unconditionally. No new access is started in DONE, because EX/MEM still holds the completed instruction.
- Byte enables:
  - byte: 0001<<addr[1:0]
  - half: 0011<<addr[1:0]
  - word: 1111
- Store data:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata
- Load data on ack: select the lane by captured addr[1:0], then sign- or zero-extend to 32 bits, and register it into rdata.
- Aborted load: rdata ← 0. Stores leave rdata unchanged.

## Timing
- Ack latency k means ack arrives k cycles after the first mem_req cycle (k=0 is the same cycle).
- For an access with ack latency k, stall is high for k+1 cycles, followed by one DONE cycle. The total access is k+2 cycles.
- Back-to-back accesses each take at least 2 cycles (IDLE→DONE), with a 1-cycle stall each.
- Timeout: stall is high for 1+TIMEOUT cycles. bus_err is raised in the following DONE cycle.
- mem_ack received outside REQ or the IDLE request cycle is ignored.
- Reset values while rstn=0 and on the following cycle:
  - state IDLE
  - rdata=0, wait counter 0
  - stall=0, mem_req=0, mem_we=0, mem_be=0
  - misalign=0, bus_err=0
  - mem_addr=0, mem_wdata=0
- Reset mid-REQ abandons the access with no flags. Sync reset overrides all other events in the same cycle.

## Test plan
- LB, addr=0x003, sign=1, mem_rdata=0x80FF1234, ack k=0: mem_be=1000, stall high 1 cycle, rdata=0xFFFFFF80 in DONE. Repeat with sign=0: rdata=0x00000080.
- SH, addr=0x006, wdata=0x0000ABCD, ack k=1: mem_we=1, mem_addr=1, mem_be=1100, mem_wdata=0xABCDABCD held stable over 2 cycles, stall high 2 cycles, rdata unchanged.
- LW, addr=0x010, ack k=3, mem_rdata=0xDEADBEEF: mem_addr=4, stall high 4 cycles, rdata=0xDEADBEEF in DONE. A second LW right after the first takes its own IDLE request cycle.
- LH at addr=0x005, and LW with length=11: misalign=1 for one cycle, mem_req=0, stall=0, rdata unchanged.
- LW with no ack and TIMEOUT=15: stall high 16 cycles, then DONE with bus_err=1, rdata=0, mem_req=0. A late ack in IDLE is ignored.
- rstn low during the 2nd REQ cycle of a load: next cycle IDLE, mem_req=0, stall=0, rdata=0, no flags.
